// File: rtl/data_memory_mc.sv
// Multi-cycle data memory for the RISC-V load/store path.
// Fixed-latency access sequenced by an FSM; busywait stalls the CPU.
module data_memory_mc #(
   parameter int DW      = 8,
   parameter int W       = 256,
   parameter int AW      = 8,
   parameter int LATENCY = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          read,
   input  logic          write,
   input  logic [AW-1:0] address,
   input  logic [DW-1:0] writedata,
   output logic [DW-1:0] readdata,
   output logic          busywait,
   output logic          error
);

   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [AW:0] W_LIM = (AW + 1)'(W);
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic          op_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [CW-1:0] cnt_q;

   logic [DW-1:0] mem [0:W-1];

   logic in_range;
   logic req_ok;
   logic req_bad;
   logic is_idle;
   logic cnt_zero;

   // Exactly one request line and a valid address is a legal access
   assign in_range = {1'b0, address} < W_LIM;
   assign req_ok   = (read ^ write) & in_range;
   assign req_bad  = (read & write) | ((read | write) & ~in_range);
   assign is_idle  = state == IDLE;
   assign cnt_zero = cnt_q == '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (req_ok) begin
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_zero) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      busywait = 1'b0;
      unique case (1'b1)
         state == ACCESS: busywait = 1'b1;
         is_idle:         busywait = req_ok;
         default:         busywait = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
      end else if (is_idle && req_ok) begin
         op_q    <= write;
         addr_q  <= address;
         wdata_q <= writedata;
         cnt_q   <= CNT_INIT;
      end else if (state == ACCESS && !cnt_zero) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   // Reset clears the array, so an aborted write can never surface
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < W; i++) begin
            mem[i] <= '0;
         end
      end else if (state == ACCESS && cnt_zero && op_q) begin
         mem[addr_q] <= wdata_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= '0;
      end else if (state == ACCESS && cnt_zero && !op_q) begin
         readdata <= mem[addr_q];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         error <= 1'b0;
      end else begin
         error <= is_idle & req_bad;
      end
   end

endmodule

// File: tb/tb_data_memory_mc.sv
// Scoreboard bench for data_memory_mc across three parameter sets.
// A driver pushes expected completions; a negedge monitor pops and checks.
module tb_data_memory_mc;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       read = 1'b0;
   logic       write = 1'b0;
   logic [7:0] address = '0;
   logic [7:0] writedata = '0;

   logic [7:0] rd0, rd1, rd2;
   logic       bw0, bw1, bw2;
   logic       er0, er1, er2;

   always #5 clk = ~clk;

   data_memory_mc #(.DW(8), .W(256), .AW(8), .LATENCY(5)) u_main (
      .clk(clk), .reset(reset), .read(read), .write(write),
      .address(address), .writedata(writedata),
      .readdata(rd0), .busywait(bw0), .error(er0)
   );

   data_memory_mc #(.DW(8), .W(200), .AW(8), .LATENCY(5)) u_w200 (
      .clk(clk), .reset(reset), .read(read), .write(write),
      .address(address), .writedata(writedata),
      .readdata(rd1), .busywait(bw1), .error(er1)
   );

   data_memory_mc #(.DW(8), .W(256), .AW(8), .LATENCY(1)) u_lat1 (
      .clk(clk), .reset(reset), .read(read), .write(write),
      .address(address), .writedata(writedata),
      .readdata(rd2), .busywait(bw2), .error(er2)
   );

   int sel = 0;
   int cur_w = 256;
   int cur_lat = 5;

   logic [7:0] m_rd;
   logic       m_busy;
   logic       m_err;

   always_comb begin
      m_rd = rd0;
      m_busy = bw0;
      m_err = er0;
      case (sel)
         1: begin
            m_rd = rd1; m_busy = bw1; m_err = er1;
         end
         2: begin
            m_rd = rd2; m_busy = bw2; m_err = er2;
         end
         default: ;
      endcase
   end

   typedef struct {
      bit         illegal;
      logic [7:0] rd;
   } exp_t;

   exp_t q[$];
   int n_tests = 0;
   int n_fail = 0;

   logic [7:0] mdl_mem [256];
   logic [7:0] mdl_rd;

   function automatic void check(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (sel=%0d t=%0t)",
                  name, act, exp, sel, $time);
      end
   endfunction

   // Monitor: a busywait run ending, or an error pulse, is one response
   int run = 0;
   bit rst_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         run = 0;
      end else begin
         if (rst_prev) begin
            check("reset_busywait", int'(m_busy), 0);
            check("reset_readdata", int'(m_rd), 0);
            check("reset_error", int'(m_err), 0);
         end
         if (m_busy) begin
            run++;
         end else if (run > 0) begin
            if (q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = q.pop_front();
               check("done_was_legal", int'(e.illegal), 0);
               check("busy_len", run, cur_lat + 1);
               check("readdata", int'(m_rd), int'(e.rd));
            end
            run = 0;
         end
         if (m_err) begin
            if (q.size() == 0) begin
               check("unexpected_error", 1, 0);
            end else begin
               e = q.pop_front();
               check("err_was_illegal", int'(e.illegal), 1);
               check("err_busywait", int'(m_busy), 0);
               check("err_readdata", int'(m_rd), int'(e.rd));
            end
         end
      end
      rst_prev = reset;
   end

   task automatic do_reset(input int cycles);
      @(posedge clk);
      #1;
      reset = 1'b1;
      read = 1'b0;
      write = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      reset = 1'b0;
      check("queue_empty_at_reset", q.size(), 0);
      q.delete();
      for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
      mdl_rd = '0;
   endtask

   task automatic do_idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         read = 1'b0;
         write = 1'b0;
      end
   endtask

   task automatic do_req(input bit r, input bit w,
                         input logic [7:0] a, input logic [7:0] d);
      bit legal;
      @(posedge clk);
      #1;
      read = r;
      write = w;
      address = a;
      writedata = d;
      legal = (r ^ w) && (int'(a) < cur_w);
      if (legal) begin
         if (w) mdl_mem[a] = d;
         else mdl_rd = mdl_mem[a];
         q.push_back('{illegal: 1'b0, rd: mdl_rd});
         for (int k = 0; ; k++) begin
            @(negedge clk);
            if (!m_busy) break;
            if (k >= 20) begin
               check("busy_timeout", k, 0);
               break;
            end
            // Latched values must win over whatever the bus shows now
            @(posedge clk);
            #1;
            address = 8'($urandom);
            writedata = 8'($urandom);
         end
      end else begin
         q.push_back('{illegal: 1'b1, rd: mdl_rd});
         @(negedge clk);
         @(posedge clk);
         #1;
         read = 1'b0;
         write = 1'b0;
      end
   endtask

   task automatic rand_ops(input int n);
      int x;
      logic [7:0] a;
      for (int i = 0; i < n; i++) begin
         x = $urandom_range(0, 9);
         a = $urandom_range(0, 1) ? 8'($urandom_range(0, 15))
                                  : 8'($urandom_range(0, 255));
         if (x < 5) do_req(1'b1, 1'b0, a, 8'($urandom));
         else if (x < 9) do_req(1'b0, 1'b1, a, 8'($urandom));
         else do_req(1'b1, 1'b1, a, 8'($urandom));
         if ($urandom_range(0, 3) == 0) do_idle($urandom_range(1, 3));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      sel = 0;
      cur_w = 256;
      cur_lat = 5;
      do_reset(1);
      do_req(1'b1, 1'b0, 8'h10, 8'h00);
      do_req(1'b0, 1'b1, 8'h3C, 8'hA5);
      do_req(1'b1, 1'b0, 8'h3C, 8'h00);
      do_req(1'b0, 1'b1, 8'h01, 8'h5A);
      do_req(1'b1, 1'b1, 8'h01, 8'hFF);
      do_req(1'b1, 1'b0, 8'h01, 8'h00);
      do_idle(2);
      // Reset lands on the 3rd edge after accept: the write is lost
      @(posedge clk);
      #1;
      write = 1'b1;
      address = 8'h05;
      writedata = 8'h77;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      write = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
      mdl_rd = '0;
      do_req(1'b1, 1'b0, 8'h05, 8'h00);
      do_req(1'b0, 1'b1, 8'h05, 8'h11);
      do_req(1'b0, 1'b1, 8'h06, 8'h22);
      do_req(1'b1, 1'b0, 8'h05, 8'h00);
      rand_ops(60);
      do_idle(3);

      sel = 1;
      cur_w = 200;
      do_reset(2);
      do_req(1'b0, 1'b1, 8'd200, 8'h33);
      do_req(1'b1, 1'b0, 8'd200, 8'h00);
      do_req(1'b1, 1'b0, 8'd199, 8'h00);
      do_req(1'b0, 1'b1, 8'd199, 8'h44);
      do_req(1'b1, 1'b0, 8'd199, 8'h00);
      do_req(1'b0, 1'b1, 8'd255, 8'h99);
      rand_ops(60);
      do_idle(3);

      sel = 2;
      cur_w = 256;
      cur_lat = 1;
      do_reset(1);
      do_req(1'b0, 1'b1, 8'h07, 8'h9C);
      repeat (4) do_req(1'b1, 1'b0, 8'h07, 8'h00);
      do_req(1'b1, 1'b0, 8'h08, 8'h00);
      rand_ops(60);
      do_idle(3);

      check("queue_empty_at_end", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
